twiddle_cmult: RTL
==================

# twiddle_cmult

Pipelined complex multiplier that sits directly downstream of the twiddle-coefficient sequencer. It multiplies each incoming complex sample by the coefficient presented on the same clock. Results are rounded and saturated back to NBITS, a frame-start marker is generated, and sticky status flags are kept for saturation and stream gaps. Its output feeds the next butterfly stage of the N-point FFT.

## Interface
Parameters:
- NBITS, 11, width of each real/imag component (data in, coefficient, data out)
- N, 32, frame length; the coefficient sequencer wraps every N cycles
- COEF_FRAC, 9, fractional bits of the coefficient; coefficient value 1.0 = 2^COEF_FRAC

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- coeff_in  in  2*NBITS  coefficient from the sequencer: [2*NBITS-1:NBITS] = real, [NBITS-1:0] = imag, signed
- in_valid  in  1  sample valid
- in_re  in  NBITS  sample real part, signed
- in_im  in  NBITS  sample imaginary part, signed
- out_valid  out  1  result valid
- out_re  out  NBITS  result real part, signed
- out_im  out  NBITS  result imaginary part, signed
- out_sof  out  1  high with out_valid on the first result of each frame
- sat_flag  out  1  sticky: any saturation since reset or clr_flags
- gap_err  out  1  sticky: in_valid dropped mid-frame
- clr_flags  in  1  clears sat_flag and gap_err

## Operation
- Product: re = dr·cr − di·ci, im = dr·ci + di·cr. Full precision is 2·NBITS+1 bits, signed.
- Rounding: add 2^(COEF_FRAC−1), then arithmetic shift right by COEF_FRAC (round half toward +inf).
- Saturation: clamp to [−2^(NBITS−1), 2^(NBITS−1)−1]. Any clamp on re or im with valid data sets sat_flag.
- Frame counter cnt (0..N−1) counts accepted samples (in_valid=1) and wraps N−1 → 0. in_sof = in_valid && cnt==0; it travels down the pipeline with the data.
- The coefficient source advances every clock unconditionally, so frames must be gap-free. If in_valid=0 while cnt≠0, gap_err is set and cnt is forced to 0. The next valid sample then starts a new frame.
- Idle cycles with cnt==0 are legal and do not set gap_err.
- No backpressure. The output is consumed every cycle it is valid.
- clr_flags has priority below rst and above set. If a set event and clr_flags occur on the same cycle, the flag is 0 afterwards.

## Timing
- Latency: 3 cycles, in_valid → out_valid. Throughput: 1 sample per clock.
- S1 registers the four NBITS×NBITS products plus valid/sof.
- S2 registers the sum/difference with the rounding constant added.
- S3 registers the shifted, saturated out_re/out_im, out_valid, out_sof, and updates sat_flag.
- coeff_in is sampled on the same edge as in_re/in_im; no coefficient delay is applied inside the block.
- out_re/out_im hold their last value when out_valid=0.
- Reset values: out_valid=0, out_re=0, out_im=0, out_sof=0, sat_flag=0, gap_err=0, cnt=0, all pipeline valid bits 0.
- rst mid-frame flushes the pipeline. No stale out_valid appears after rst is released.
- gap_err updates one cycle after the offending in_valid=0 edge.

## Structure
- Shared FFT package holds: the complex packing order (real in upper half), the rounding/saturation helper function, and the default NBITS/COEF_FRAC constants.
- One natural sub-module: sat_round. It is combinational, takes a (2·NBITS+1)-bit input, produces NBITS output plus an overflow bit, and is instantiated twice (re, im).
- Frame counter and flag logic stay in the top module.

## Test plan
NBITS=11, COEF_FRAC=9, N=32 throughout.

- Identity: coeff=(512,0), data=(100,−50) → 3 cycles later out=(100,−50), sat_flag=0.
- −j twiddle: coeff=(0,−512), data=(100,−50) → out=(−50,−100).
- Rounding: coeff=(256,0), data=(1,0) → out_re=1; data=(−1,0) → out_re=0.
- Saturation: coeff=(512,512), data=(1023,1023) → out=(0,1023), sat_flag=1 and stays 1; clr_flags pulse → sat_flag=0.
- Framing: 64 continuous valid samples → out_sof high on result 0 and result 32 only. Deassert in_valid at sample 10 → gap_err=1, and the next valid sample gets out_sof.
- Reset mid-stream: assert rst for 1 cycle during frame → all outputs 0 the next cycle, no out_valid for the 3 flushed samples. The next valid sample gets out_sof.

Source files
------------

// File: rtl/twiddle_cmult_pkg.sv
// Shared FFT definitions: default widths, complex packing order, and the
// shift/saturate helpers used by the rounding stage.
package twiddle_cmult_pkg;

  localparam int DEF_NBITS     = 11;
  localparam int DEF_N         = 32;
  localparam int DEF_COEF_FRAC = 9;

  // Packed complex word: real part in the upper half, imaginary in the lower.
  localparam int CPLX_RE_HALF = 1;
  localparam int CPLX_IM_HALF = 0;

  function automatic logic signed [63:0] round_const(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

  function automatic logic signed [63:0] sat_max(input int nbits);
    return (64'sd1 <<< (nbits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int nbits);
    return -(64'sd1 <<< (nbits - 1));
  endfunction

  // Arithmetic shift (rounding constant already added) then clamp.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] x,
                                                   input int nbits, input int frac);
    logic signed [63:0] s;
    s = x >>> frac;
    if (s > sat_max(nbits)) return sat_max(nbits);
    if (s < sat_min(nbits)) return sat_min(nbits);
    return s;
  endfunction

  function automatic logic sat_ovf(input logic signed [63:0] x,
                                   input int nbits, input int frac);
    logic signed [63:0] s;
    s = x >>> frac;
    return (s > sat_max(nbits)) || (s < sat_min(nbits));
  endfunction

endpackage

// File: rtl/twiddle_cmult_sat_round.sv
// Combinational shift-and-saturate of a full-precision product sum back to
// NBITS; ovf_o flags that the clamp was applied.
module twiddle_cmult_sat_round
  import twiddle_cmult_pkg::*;
#(
  parameter int NBITS     = DEF_NBITS,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic signed [2*NBITS:0]  x_i,
  output logic signed [NBITS-1:0]  y_o,
  output logic                     ovf_o
);

  logic signed [63:0] x_ext;

  assign x_ext = 64'(x_i);
  assign y_o   = NBITS'(sat_shift(x_ext, NBITS, COEF_FRAC));
  assign ovf_o = sat_ovf(x_ext, NBITS, COEF_FRAC);

endmodule

// File: rtl/twiddle_cmult.sv
// Three-stage pipelined complex multiplier (sample x twiddle) with round/
// saturate, frame-start tagging and sticky saturation / gap status flags.
module twiddle_cmult
  import twiddle_cmult_pkg::*;
#(
  parameter int NBITS     = DEF_NBITS,
  parameter int N         = DEF_N,
  parameter int COEF_FRAC = DEF_COEF_FRAC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NBITS-1:0]      coeff_in,
  input  logic                    in_valid,
  input  logic signed [NBITS-1:0] in_re,
  input  logic signed [NBITS-1:0] in_im,
  output logic                    out_valid,
  output logic signed [NBITS-1:0] out_re,
  output logic signed [NBITS-1:0] out_im,
  output logic                    out_sof,
  output logic                    sat_flag,
  output logic                    gap_err,
  input  logic                    clr_flags
);

  localparam int PW   = 2 * NBITS;
  localparam int ACCW = 2 * NBITS + 1;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic signed [ACCW-1:0] RND = ACCW'(round_const(COEF_FRAC));

  logic signed [NBITS-1:0] c_re;
  logic signed [NBITS-1:0] c_im;

  assign c_re = coeff_in[CPLX_RE_HALF*NBITS +: NBITS];
  assign c_im = coeff_in[CPLX_IM_HALF*NBITS +: NBITS];

  // Frame counter and input-side framing
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_sof;
  logic          gap_evt;

  assign in_sof  = in_valid && (cnt_q == '0);
  assign gap_evt = !in_valid && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // S1: partial products rr, ii, ri, ir
  logic signed [PW-1:0] prod_q [4];
  logic                 v1_q, sof1_q;

  always_ff @(posedge clk) begin
    prod_q[0] <= PW'(in_re) * PW'(c_re);
    prod_q[1] <= PW'(in_im) * PW'(c_im);
    prod_q[2] <= PW'(in_re) * PW'(c_im);
    prod_q[3] <= PW'(in_im) * PW'(c_re);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      sof1_q <= 1'b0;
    end else begin
      v1_q   <= in_valid;
      sof1_q <= in_sof;
    end
  end

  // S2: sums with the half-LSB rounding constant folded in; [0]=re, [1]=im
  logic signed [ACCW-1:0] acc_q [2];
  logic signed [ACCW-1:0] acc_d [2];
  logic                   v2_q, sof2_q;

  always_comb begin
    acc_d[0] = ACCW'(prod_q[0]) - ACCW'(prod_q[1]) + RND;
    acc_d[1] = ACCW'(prod_q[2]) + ACCW'(prod_q[3]) + RND;
  end

  always_ff @(posedge clk) begin
    acc_q[0] <= acc_d[0];
    acc_q[1] <= acc_d[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q   <= 1'b0;
      sof2_q <= 1'b0;
    end else begin
      v2_q   <= v1_q;
      sof2_q <= sof1_q;
    end
  end

  // S3: shift/saturate both components
  logic signed [NBITS-1:0] sr_y [2];
  logic [1:0]              sr_ovf;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sat
      twiddle_cmult_sat_round #(
        .NBITS     (NBITS),
        .COEF_FRAC (COEF_FRAC)
      ) u_sat_round (
        .x_i   (acc_q[gi]),
        .y_o   (sr_y[gi]),
        .ovf_o (sr_ovf[gi])
      );
    end
  endgenerate

  logic                    out_valid_q;
  logic                    out_sof_q;
  logic signed [NBITS-1:0] out_re_q;
  logic signed [NBITS-1:0] out_im_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      out_valid_q <= v2_q;
      out_sof_q   <= v2_q && sof2_q;
      if (v2_q) begin
        out_re_q <= sr_y[0];
        out_im_q <= sr_y[1];
      end
    end
  end

  // Sticky flags: clear wins over a coincident set
  logic sat_q, sat_d;
  logic gap_q, gap_d;

  always_comb begin
    sat_d = sat_q;
    gap_d = gap_q;
    if (v2_q && (|sr_ovf)) sat_d = 1'b1;
    if (gap_evt)           gap_d = 1'b1;
    if (clr_flags) begin
      sat_d = 1'b0;
      gap_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q <= 1'b0;
      gap_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      gap_q <= gap_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign sat_flag  = sat_q;
  assign gap_err   = gap_q;

endmodule
